// File: rtl/ahb3lite_pkg.sv
// ---------------------------------------------------------------------------
// ahb3lite_pkg
// Shared AHB3-Lite encodings used across the interconnect.
//   HTRANS_* : transfer type codes (IDLE, BUSY, NONSEQ, SEQ)
//   HBURST_* : burst type codes (SINGLE, INCR, WRAPx, INCRx)
//   burst_beats(): beat count of a fixed-length burst, 0 for SINGLE/INCR
// ---------------------------------------------------------------------------
package ahb3lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;
  localparam logic [2:0] HBURST_WRAP16 = 3'b110;
  localparam logic [2:0] HBURST_INCR16 = 3'b111;

  // Number of beats in a fixed-length burst. SINGLE and INCR have no
  // predetermined length and report 0.
  function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
    logic [4:0] beats;
    beats = 5'd0;
    case (hburst)
      HBURST_WRAP4,  HBURST_INCR4:  beats = 5'd4;
      HBURST_WRAP8,  HBURST_INCR8:  beats = 5'd8;
      HBURST_WRAP16, HBURST_INCR16: beats = 5'd16;
      default:                      beats = 5'd0;
    endcase
    return beats;
  endfunction

endpackage

// File: rtl/ahb3lite_interconnect_switch_ctrl.sv
// ---------------------------------------------------------------------------
// ahb3lite_interconnect_switch_ctrl
// Per-master switch controller. Watches one master's address phase and tells
// every slave-port arbiter whether grant may be taken away from this master
// at the next HREADY edge. Switching is blocked during fixed-length bursts,
// locked sequences and (up to MAX_INCR_BEATS beats) undefined-length bursts.
//
// Ports:
//   HCLK, HRESETn   : clock (rising edge) and async active-low reset
//   HSEL            : master addresses this interconnect (0 acts as IDLE)
//   HTRANS, HBURST  : master transfer type and burst type
//   HMASTLOCK       : master lock request
//   HREADY          : bus ready; a transfer is accepted on an edge with 1
//   can_switch      : 1 = arbiter may move grant away at the next edge
//   burst_active    : controller is tracking a burst or lock
//   beat_cnt        : FIXED beats remaining, INCR beats accepted, else 0
// ---------------------------------------------------------------------------
module ahb3lite_interconnect_switch_ctrl
  import ahb3lite_pkg::*;
#(
  parameter  int MAX_INCR_BEATS = 16,
  localparam int CNT_BITS       = $clog2(MAX_INCR_BEATS) + 1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                HSEL,
  input  logic [1:0]          HTRANS,
  input  logic [2:0]          HBURST,
  input  logic                HMASTLOCK,
  input  logic                HREADY,
  output logic                can_switch,
  output logic                burst_active,
  output logic [CNT_BITS-1:0] beat_cnt
);

  // The internal counter must also hold a 16-beat fixed burst length, even
  // when the INCR limit is configured smaller than that.
  localparam int CW = (CNT_BITS > 5) ? CNT_BITS : 5;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIXED,
    ST_INCR,
    ST_LOCKED
  } state_e;

  state_e          st_q, st_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [1:0]      eff_trans;
  logic            acc;
  logic [CW-1:0]   fixed_len;
  logic            is_fixed;
  logic            is_incr;
  logic            cnt_is_one;
  logic            cnt_is_max;
  state_e          idle_st;
  logic [CW-1:0]   idle_cnt;

  // An unselected master is indistinguishable from one driving IDLE, so all
  // decisions below look at the effective transfer type only.
  always_comb begin
    eff_trans  = HSEL ? HTRANS : HTRANS_IDLE;
    acc        = HREADY && ((eff_trans == HTRANS_NONSEQ) || (eff_trans == HTRANS_SEQ));
    fixed_len  = CW'(burst_beats(HBURST));
    is_fixed   = (fixed_len != '0);
    is_incr    = (HBURST == HBURST_INCR);
    cnt_is_one = (cnt_q == CW'(1));
    cnt_is_max = (cnt_q == CW'(MAX_INCR_BEATS));
  end

  // Burst-start decision shared by IDLE, restarts from FIXED/INCR and the
  // exit from LOCKED: a NONSEQ beat opens a FIXED or INCR burst, anything
  // else leaves the controller idle.
  always_comb begin
    idle_st  = ST_IDLE;
    idle_cnt = '0;
    if (acc && (eff_trans == HTRANS_NONSEQ)) begin
      if (is_fixed) begin
        idle_st  = ST_FIXED;
        idle_cnt = fixed_len - CW'(1);
      end else if (is_incr) begin
        idle_st  = ST_INCR;
        idle_cnt = CW'(1);
      end
    end
  end

  // Next-state and counter logic. Nothing moves on a wait state; a locked
  // accepted transfer overrides every other transition.
  always_comb begin
    st_d  = st_q;
    cnt_d = cnt_q;
    if (HREADY) begin
      if (acc && HMASTLOCK) begin
        st_d  = ST_LOCKED;
        cnt_d = '0;
      end else begin
        case (st_q)
          ST_IDLE: begin
            st_d  = idle_st;
            cnt_d = idle_cnt;
          end
          ST_FIXED: begin
            case (eff_trans)
              HTRANS_SEQ: begin
                if (cnt_is_one) begin
                  st_d  = ST_IDLE;
                  cnt_d = '0;
                end else begin
                  cnt_d = cnt_q - CW'(1);
                end
              end
              HTRANS_BUSY: begin
                st_d  = st_q;
                cnt_d = cnt_q;
              end
              HTRANS_NONSEQ: begin
                st_d  = idle_st;
                cnt_d = idle_cnt;
              end
              default: begin
                st_d  = ST_IDLE;
                cnt_d = '0;
              end
            endcase
          end
          ST_INCR: begin
            case (eff_trans)
              HTRANS_SEQ: begin
                if (!cnt_is_max) begin
                  cnt_d = cnt_q + CW'(1);
                end
              end
              HTRANS_BUSY: begin
                st_d  = st_q;
                cnt_d = cnt_q;
              end
              HTRANS_NONSEQ: begin
                st_d  = idle_st;
                cnt_d = idle_cnt;
              end
              default: begin
                st_d  = ST_IDLE;
                cnt_d = '0;
              end
            endcase
          end
          ST_LOCKED: begin
            if (!HMASTLOCK) begin
              st_d  = idle_st;
              cnt_d = idle_cnt;
            end
          end
          default: begin
            st_d  = ST_IDLE;
            cnt_d = '0;
          end
        endcase
      end
    end
  end

  // State and counter registers; reset drops any burst in progress.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

  // can_switch is combinational from state and the live address phase.
  // While reset is held the output shows its idle value regardless of what
  // the master is driving.
  always_comb begin
    can_switch = 1'b1;
    if (!HRESETn) begin
      can_switch = 1'b1;
    end else if (HSEL && HMASTLOCK) begin
      can_switch = 1'b0;
    end else begin
      case (st_q)
        ST_LOCKED: can_switch = 1'b0;
        ST_IDLE:   can_switch = !((eff_trans == HTRANS_NONSEQ) && (is_fixed || is_incr));
        ST_FIXED:  can_switch = (cnt_is_one && (eff_trans == HTRANS_SEQ)) ||
                                (eff_trans == HTRANS_IDLE);
        ST_INCR:   can_switch = (eff_trans == HTRANS_IDLE) ||
                                (eff_trans == HTRANS_NONSEQ) || cnt_is_max;
        default:   can_switch = 1'b1;
      endcase
    end
  end

  assign burst_active = (st_q != ST_IDLE);
  assign beat_cnt     = cnt_q[CNT_BITS-1:0];

endmodule

// File: tb/tb_ahb3lite_interconnect_switch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ahb3lite_interconnect_switch_ctrl
// Directed bench for the per-master switch controller. Each step drives one
// address-phase cycle, checks can_switch before the edge, then checks the
// registered counter and burst_active just after the edge.
// ---------------------------------------------------------------------------
module tb_ahb3lite_interconnect_switch_ctrl;
  import ahb3lite_pkg::*;

  logic       HCLK;
  logic       HRESETn;
  logic       HSEL;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HMASTLOCK;
  logic       HREADY;
  logic       can_switch;
  logic       burst_active;
  logic [4:0] beat_cnt;

  int vectors    = 0;
  int miscompares = 0;

  ahb3lite_interconnect_switch_ctrl #(.MAX_INCR_BEATS(16)) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .HSEL         (HSEL),
    .HTRANS       (HTRANS),
    .HBURST       (HBURST),
    .HMASTLOCK    (HMASTLOCK),
    .HREADY       (HREADY),
    .can_switch   (can_switch),
    .burst_active (burst_active),
    .beat_cnt     (beat_cnt)
  );

  // Free-running 100 MHz clock.
  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Safety net so a stuck run still ends with a report.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drive one address-phase cycle and let combinational outputs settle.
  task automatic applyStimulus(input logic sel, input logic [1:0] trans,
                               input logic [2:0] burst, input logic lock,
                               input logic ready);
    HSEL      = sel;
    HTRANS    = trans;
    HBURST    = burst;
    HMASTLOCK = lock;
    HREADY    = ready;
    #1;
  endtask

  // Single comparison point: counts the vector and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Advance past the next rising edge so registered outputs can be sampled.
  task automatic clockEdge();
    @(posedge HCLK);
    #1;
  endtask

  // One full bus cycle: drive, check can_switch, clock, check registers.
  task automatic runCycle(input string tag, input logic sel, input logic [1:0] trans,
                          input logic [2:0] burst, input logic lock, input logic ready,
                          input logic exp_cs, input logic [4:0] exp_cnt,
                          input logic exp_ba);
    applyStimulus(sel, trans, burst, lock, ready);
    checkOutput({tag, ".cs"}, {31'd0, can_switch}, {31'd0, exp_cs});
    clockEdge();
    checkOutput({tag, ".cnt"}, {27'd0, beat_cnt}, {27'd0, exp_cnt});
    checkOutput({tag, ".ba"}, {31'd0, burst_active}, {31'd0, exp_ba});
  endtask

  // Directed sequence covering reset, fixed and undefined bursts, waits,
  // saturation, locking, early termination and mid-burst reset.
  initial begin
    logic [4:0] model_cnt;
    logic [4:0] next_cnt;
    logic       exp_cs;

    HRESETn = 1'b0;
    applyStimulus(1'b1, HTRANS_NONSEQ, HBURST_INCR4, 1'b0, 1'b1);
    checkOutput("rst.cs", {31'd0, can_switch}, 32'd1);
    checkOutput("rst.ba", {31'd0, burst_active}, 32'd0);
    checkOutput("rst.cnt", {27'd0, beat_cnt}, 32'd0);
    clockEdge();
    checkOutput("rst_edge.cnt", {27'd0, beat_cnt}, 32'd0);
    checkOutput("rst_edge.ba", {31'd0, burst_active}, 32'd0);

    @(negedge HCLK);
    applyStimulus(1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 1'b1);
    HRESETn = 1'b1;
    clockEdge();
    checkOutput("post_rst.cs", {31'd0, can_switch}, 32'd1);

    // INCR4 without wait states.
    runCycle("incr4_b1", 1'b1, HTRANS_NONSEQ, HBURST_INCR4, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1);
    runCycle("incr4_b2", 1'b1, HTRANS_SEQ,    HBURST_INCR4, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1);
    runCycle("incr4_b3", 1'b1, HTRANS_SEQ,    HBURST_INCR4, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
    runCycle("incr4_b4", 1'b1, HTRANS_SEQ,    HBURST_INCR4, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);
    runCycle("incr4_idle", 1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);

    // WRAP8 with two wait states on beat 3 and a BUSY cycle after beat 5.
    runCycle("wrap8_b1",  1'b1, HTRANS_NONSEQ, HBURST_WRAP8, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1);
    runCycle("wrap8_b2",  1'b1, HTRANS_SEQ,    HBURST_WRAP8, 1'b0, 1'b1, 1'b0, 5'd6, 1'b1);
    runCycle("wrap8_w1",  1'b1, HTRANS_SEQ,    HBURST_WRAP8, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1);
    runCycle("wrap8_w2",  1'b1, HTRANS_SEQ,    HBURST_WRAP8, 1'b0, 1'b0, 1'b0, 5'd6, 1'b1);
    runCycle("wrap8_b3",  1'b1, HTRANS_SEQ,    HBURST_WRAP8, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1);
    runCycle("wrap8_b4",  1'b1, HTRANS_SEQ,    HBURST_WRAP8, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1);
    runCycle("wrap8_b5",  1'b1, HTRANS_SEQ,    HBURST_WRAP8, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1);
    runCycle("wrap8_bsy", 1'b1, HTRANS_BUSY,   HBURST_WRAP8, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1);
    runCycle("wrap8_b6",  1'b1, HTRANS_SEQ,    HBURST_WRAP8, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1);
    runCycle("wrap8_b7",  1'b1, HTRANS_SEQ,    HBURST_WRAP8, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
    runCycle("wrap8_b8",  1'b1, HTRANS_SEQ,    HBURST_WRAP8, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);

    // Undefined-length INCR burst, 20 SEQ beats, saturating at 16.
    runCycle("incr_ns", 1'b1, HTRANS_NONSEQ, HBURST_INCR, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
    model_cnt = 5'd1;
    for (int i = 1; i <= 20; i++) begin
      exp_cs   = (model_cnt == 5'd16);
      next_cnt = (model_cnt < 5'd16) ? model_cnt + 5'd1 : 5'd16;
      runCycle($sformatf("incr_sat%0d", i), 1'b1, HTRANS_SEQ, HBURST_INCR, 1'b0, 1'b1,
               exp_cs, next_cnt, 1'b1);
      model_cnt = next_cnt;
    end
    runCycle("incr_sat_end", 1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);

    // Short INCR burst (5 beats) ended by IDLE.
    runCycle("incr5_b1", 1'b1, HTRANS_NONSEQ, HBURST_INCR, 1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
    runCycle("incr5_b2", 1'b1, HTRANS_SEQ,    HBURST_INCR, 1'b0, 1'b1, 1'b0, 5'd2, 1'b1);
    runCycle("incr5_b3", 1'b1, HTRANS_SEQ,    HBURST_INCR, 1'b0, 1'b1, 1'b0, 5'd3, 1'b1);
    runCycle("incr5_b4", 1'b1, HTRANS_SEQ,    HBURST_INCR, 1'b0, 1'b1, 1'b0, 5'd4, 1'b1);
    runCycle("incr5_b5", 1'b1, HTRANS_SEQ,    HBURST_INCR, 1'b0, 1'b1, 1'b0, 5'd5, 1'b1);
    runCycle("incr5_idle", 1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);

    // INCR interrupted by a new NONSEQ INCR4: switch allowed, restart as FIXED.
    runCycle("restart_ns", 1'b1, HTRANS_NONSEQ, HBURST_INCR,  1'b0, 1'b1, 1'b0, 5'd1, 1'b1);
    runCycle("restart_i4", 1'b1, HTRANS_NONSEQ, HBURST_INCR4, 1'b0, 1'b1, 1'b1, 5'd3, 1'b1);
    runCycle("restart_dsl", 1'b0, HTRANS_SEQ,   HBURST_INCR4, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);

    // Locked sequence of three SINGLE transfers, then unlock.
    runCycle("lock_s1", 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
    runCycle("lock_s2", 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
    runCycle("lock_s3", 1'b1, HTRANS_NONSEQ, HBURST_SINGLE, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
    runCycle("lock_rel", 1'b1, HTRANS_IDLE,  HBURST_SINGLE, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
    runCycle("lock_aft", 1'b1, HTRANS_IDLE,  HBURST_SINGLE, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);

    // INCR8 aborted by IDLE after beat 2.
    runCycle("abort_b1", 1'b1, HTRANS_NONSEQ, HBURST_INCR8, 1'b0, 1'b1, 1'b0, 5'd7, 1'b1);
    runCycle("abort_b2", 1'b1, HTRANS_SEQ,    HBURST_INCR8, 1'b0, 1'b1, 1'b0, 5'd6, 1'b1);
    runCycle("abort_idle", 1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);

    // Reset asserted in the middle of an INCR16 burst, away from any edge.
    runCycle("i16_b1", 1'b1, HTRANS_NONSEQ, HBURST_INCR16, 1'b0, 1'b1, 1'b0, 5'd15, 1'b1);
    runCycle("i16_b2", 1'b1, HTRANS_SEQ,    HBURST_INCR16, 1'b0, 1'b1, 1'b0, 5'd14, 1'b1);
    runCycle("i16_b3", 1'b1, HTRANS_SEQ,    HBURST_INCR16, 1'b0, 1'b1, 1'b0, 5'd13, 1'b1);
    applyStimulus(1'b1, HTRANS_SEQ, HBURST_INCR16, 1'b0, 1'b1);
    checkOutput("i16_b4.cs", {31'd0, can_switch}, 32'd0);
    #1;
    HRESETn = 1'b0;
    #1;
    checkOutput("midrst.cs", {31'd0, can_switch}, 32'd1);
    checkOutput("midrst.ba", {31'd0, burst_active}, 32'd0);
    checkOutput("midrst.cnt", {27'd0, beat_cnt}, 32'd0);

    @(negedge HCLK);
    applyStimulus(1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 1'b1);
    HRESETn = 1'b1;
    clockEdge();
    runCycle("post_midrst", 1'b1, HTRANS_IDLE, HBURST_SINGLE, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ahb3lite_interconnect_switch_ctrl.md
Name: ahb3lite_interconnect_switch_ctrl

Overview:
Per-master-port switch controller. It watches one master's address-phase signals and drives that master's can_switch bit into every slave-port arbiter. It keeps can_switch low while a fixed-length burst, a locked sequence, or a bounded undefined-length burst is in progress. Each master port instantiates one copy; its output forms bit m of the MASTERS-wide can_switch vector.

Parameters:
MAX_INCR_BEATS, 16, accepted beats of an HBURST=INCR burst after which switching is permitted again (power of 2, at least 2).
CNT_BITS, $clog2(MAX_INCR_BEATS)+1, beat counter width (localparam in intent).

Ports:
HRESETn  input  1  asynchronous active-low reset
HCLK  input  1  clock, rising edge
HSEL  input  1  master is addressing this interconnect; 0 is treated as HTRANS=IDLE
HTRANS  input  2  master HTRANS
HBURST  input  3  master HBURST
HMASTLOCK  input  1  master HMASTLOCK
HREADY  input  1  bus HREADY seen by the master; transfer accepted on a rising edge with HREADY=1
can_switch  output  1  1 = arbiter may move grant away from this master at the next edge
burst_active  output  1  state != IDLE
beat_cnt  output  CNT_BITS  FIXED: beats remaining; INCR: beats accepted; else 0

Behaviour:
- Definitions:
  - acc = HREADY & HSEL & (HTRANS==NONSEQ | HTRANS==SEQ).
  - len(HBURST): INCR4/WRAP4=4, INCR8/WRAP8=8, INCR16/WRAP16=16; SINGLE and INCR have no fixed length.
- State register st ∈ {IDLE, FIXED, INCR, LOCKED}; counter cnt. Both reset asynchronously to IDLE and 0. Both update only on edges with HREADY=1.
- Lock priority: evaluated first from any state. acc & HMASTLOCK → LOCKED, cnt=0.
- IDLE:
  - acc & NONSEQ & fixed length → FIXED, cnt=len-1.
  - acc & NONSEQ & INCR → INCR, cnt=1.
  - Otherwise stay IDLE.
- FIXED:
  - acc & SEQ → cnt-1; when cnt==1 → IDLE, cnt=0.
  - BUSY → hold.
  - HTRANS=IDLE or HSEL=0 (early termination, e.g. after ERROR) → IDLE, cnt=0.
  - acc & NONSEQ → restart per IDLE rules.
- INCR:
  - acc & SEQ → cnt+1, saturating at MAX_INCR_BEATS.
  - BUSY → hold.
  - IDLE or HSEL=0 → IDLE.
  - NONSEQ → restart per IDLE rules.
- LOCKED: leave only on an HREADY edge with HMASTLOCK=0. Next state is then evaluated with the IDLE rules on the same edge.
- can_switch (combinational, from st, cnt and current inputs; never glitch-critical because arbiters sample it only at the HREADY edge):
  - HMASTLOCK=1 (with HSEL) → 0.
  - st=LOCKED → 0.
  - st=IDLE → 0 if the current cycle carries NONSEQ with fixed length or INCR (HSEL=1), else 1.
  - st=FIXED → 1 only if cnt==1 & HTRANS==SEQ (last beat in address phase), or HTRANS==IDLE, or HSEL=0; else 0. BUSY → 0.
  - st=INCR → 1 if HTRANS==IDLE, HSEL=0, HTRANS==NONSEQ, or cnt==MAX_INCR_BEATS; else 0.
- Reset values: can_switch=1 (inputs idle), burst_active=0, beat_cnt=0.
- Reset asserted mid-burst → IDLE immediately. No recovery of the burst.
- HREADY=0 wait states: state and counter hold. can_switch is still driven combinationally, but arbiters ignore it when HREADY=0.
- INCR saturation: after the limit, the arbiter may break the burst. The master's next SEQ then arrives at the new slave-port owner, whose port converts it to NONSEQ.

Decomposition:
- ahb3lite_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ and HBURST_* constants (existing); add function burst_beats(HBURST) returning 0/4/8/16.
- Module-local typedef enum for st.
- No sub-module; the block is a single FSM plus counter (about 150 RTL lines).

Test Plan:
- Reset: HRESETn low with HTRANS=NONSEQ INCR4 → can_switch=1, burst_active=0, beat_cnt=0. Release, then idle bus → can_switch=1.
- INCR4, no waits: NONSEQ,SEQ,SEQ,SEQ:
  - can_switch = 0,0,0,1 on the four address cycles.
  - beat_cnt after each edge = 3,2,1,0; st back to IDLE after the 4th edge.
- WRAP8 with 2 wait states on beat 3 and a BUSY cycle:
  - cnt holds during the waits and the BUSY.
  - can_switch stays 0 through beat 7 and is 1 on beat 8.
- INCR with MAX_INCR_BEATS=16: 20 SEQ beats → can_switch goes 1 when beat_cnt reaches 16 and stays 1; beat_cnt saturates at 16. A second run ended by IDLE after 5 beats → can_switch=1 on the IDLE cycle, st=IDLE.
- Locked: 3 SINGLE transfers with HMASTLOCK=1, then HMASTLOCK=0 IDLE → can_switch=0 throughout the lock and the first unlocked cycle, then 1.
- Early termination: INCR8 aborted with IDLE after beat 2 → can_switch=1 that cycle, st=IDLE. Also assert reset in the middle of an INCR16 → outputs return to reset values asynchronously.
